// File: rtl/mmc1_cfg_sequencer.sv
// mmc1_cfg_sequencer: plays one MMC1 register request onto the cartridge CPU bus
// as five LSB-first serial writes (or a single D7 reset write), with idle CPU
// cycles between writes so the mapper never sees back-to-back writes.
module mmc1_cfg_sequencer #(
    parameter int unsigned M2_DIV     = 2,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [1:0] REQ_REG,
    input  logic [4:0] REQ_DATA,
    input  logic       REQ_RESET,
    output logic       DONE,
    output logic       BUSY,
    output logic       CPU_M2,
    output logic       nCPU_ROMSEL,
    output logic       nCPU_RW,
    output logic       CPU_A14,
    output logic       CPU_A13,
    output logic       CPU_D0,
    output logic       CPU_D7
);

    localparam int unsigned PH_MAX = 2 * M2_DIV - 1;
    localparam int unsigned PH_W   = (PH_MAX > 0) ? $clog2(PH_MAX + 1) : 1;
    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StWait, StWrite, StGap, StFin} state_e;

    state_e             state_q, state_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [2:0]         bi_q, bi_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [1:0]         reg_q, reg_d;
    logic [4:0]         data_q, data_d;
    logic               rst_req_q, rst_req_d;

    // Registered bus/handshake outputs, computed from next state and next phase
    logic ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic m2_q, m2_d, romsel_n_q, romsel_n_d, rw_n_q, rw_n_d, d0_q, d0_d, d7_q, d7_d;

    logic boundary;
    logic accept;
    logic wr_d;

    // Next-state logic: phase counter, request FSM and next values of every output
    always_comb begin
        boundary  = (ph_q == PH_W'(PH_MAX));  // next PH is 0: CPU cycle boundary
        ph_d      = boundary ? '0 : ph_q + PH_W'(1);
        accept    = REQ_VALID & ready_q;
        state_d   = state_q;
        bi_d      = bi_q;
        gap_d     = gap_q;
        reg_d     = reg_q;
        data_d    = data_q;
        rst_req_d = rst_req_q;

        unique case (state_q)
            StIdle, StFin: begin
                state_d = StIdle;
                if (accept) begin
                    reg_d     = REQ_REG;
                    data_d    = REQ_DATA;
                    rst_req_d = REQ_RESET;
                    bi_d      = 3'd0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (boundary) state_d = StWrite;
            end
            StWrite: begin
                if (boundary) begin
                    if (rst_req_q || bi_q == 3'd4) begin
                        state_d = StFin;
                    end else begin
                        bi_d    = bi_q + 3'd1;
                        gap_d   = GAP_W'(GAP_CYCLES - 1);
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (boundary) begin
                    if (gap_q == '0) state_d = StWrite;
                    else             gap_d   = gap_q - GAP_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        wr_d       = (state_d == StWrite);
        m2_d       = (ph_d >= PH_W'(M2_DIV));
        // ROMSEL shares the M2 edges exactly because both come from ph_d
        romsel_n_d = ~(wr_d & m2_d);
        rw_n_d     = ~wr_d;
        d0_d       = wr_d & ~rst_req_d & data_d[bi_d];
        d7_d       = wr_d & rst_req_d;
        ready_d    = (state_d == StIdle) || (state_d == StFin);
        busy_d     = (state_d == StWait) || (state_d == StWrite) || (state_d == StGap);
        done_d     = (state_d == StFin);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            ph_q       <= '0;
            bi_q       <= 3'd0;
            gap_q      <= '0;
            reg_q      <= 2'b00;
            data_q     <= 5'd0;
            rst_req_q  <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            m2_q       <= 1'b0;
            romsel_n_q <= 1'b1;
            rw_n_q     <= 1'b1;
            d0_q       <= 1'b0;
            d7_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            bi_q       <= bi_d;
            gap_q      <= gap_d;
            reg_q      <= reg_d;
            data_q     <= data_d;
            rst_req_q  <= rst_req_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            m2_q       <= m2_d;
            romsel_n_q <= romsel_n_d;
            rw_n_q     <= rw_n_d;
            d0_q       <= d0_d;
            d7_q       <= d7_d;
        end
    end

    assign REQ_READY   = ready_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign CPU_M2      = m2_q;
    assign nCPU_ROMSEL = romsel_n_q;
    assign nCPU_RW     = rw_n_q;
    assign CPU_A14     = reg_q[1];
    assign CPU_A13     = reg_q[0];
    assign CPU_D0      = d0_q;
    assign CPU_D7      = d7_q;

endmodule

// File: tb/tb_mmc1_cfg_sequencer.sv
// Directed bench for mmc1_cfg_sequencer (M2_DIV=2, GAP_CYCLES=1).
module tb_mmc1_cfg_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [1:0] REQ_REG;
    logic [4:0] REQ_DATA;
    logic       REQ_RESET;
    logic       DONE, BUSY, CPU_M2, nCPU_ROMSEL, nCPU_RW;
    logic       CPU_A14, CPU_A13, CPU_D0, CPU_D7;

    int n_cmp = 0;
    int n_bad = 0;

    // Results of the last watch() call
    int         w_nwr, w_romlow, w_rwlow, w_adiff, w_lead, w_wr2done, w_ready_hi, w_viol;
    logic       w_done;
    logic [4:0] w_d0, w_d7;
    logic [1:0] w_a;

    logic [7:0] m2v;
    int         falls;
    logic       prev;

    mmc1_cfg_sequencer #(.M2_DIV(2), .GAP_CYCLES(1)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .REQ_VALID   (REQ_VALID),
        .REQ_READY   (REQ_READY),
        .REQ_REG     (REQ_REG),
        .REQ_DATA    (REQ_DATA),
        .REQ_RESET   (REQ_RESET),
        .DONE        (DONE),
        .BUSY        (BUSY),
        .CPU_M2      (CPU_M2),
        .nCPU_ROMSEL (nCPU_ROMSEL),
        .nCPU_RW     (nCPU_RW),
        .CPU_A14     (CPU_A14),
        .CPU_A13     (CPU_A13),
        .CPU_D0      (CPU_D0),
        .CPU_D7      (CPU_D7)
    );

    always #5 CLK = ~CLK;

    task step();
        @(posedge CLK);
        #1;
    endtask

    task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request and wait (bounded) for the accepting edge
    task send(input logic [1:0] r, input logic [4:0] d, input logic rs, input bit keep);
        int t;
        REQ_REG   = r;
        REQ_DATA  = d;
        REQ_RESET = rs;
        REQ_VALID = 1'b1;
        t = 0;
        while (!REQ_READY && t < 20) begin
            step();
            t++;
        end
        step();
        if (!keep) REQ_VALID = 1'b0;
        chk("accept_busy", 32'(BUSY), 32'd1);
    endtask

    // Observe the bus until DONE (or budget expires), collecting write statistics
    task watch(input int budget, input bit wiggle);
        int  first_wr;
        logic prev_rom;
        w_nwr = 0; w_romlow = 0; w_rwlow = 0; w_adiff = 0; w_lead = 0;
        w_wr2done = -1; w_ready_hi = 0; w_viol = 0; w_done = 1'b0;
        w_d0 = 5'd0; w_d7 = 5'd0; w_a = 2'b00;
        first_wr = -1;
        prev_rom = nCPU_ROMSEL;
        for (int k = 0; k < budget && !w_done; k++) begin
            step();
            if (!nCPU_RW) begin
                w_rwlow++;
                if (first_wr < 0) first_wr = k;
            end else if (first_wr < 0) begin
                w_lead++;
            end
            if (DONE) begin
                w_done    = 1'b1;
                w_wr2done = k - first_wr;
            end else begin
                if (REQ_READY) w_ready_hi++;
                if (wiggle) begin
                    REQ_VALID = 1'($urandom_range(0, 1));
                    REQ_DATA  = 5'($urandom_range(0, 31));
                end
            end
            if (!nCPU_ROMSEL) begin
                w_romlow++;
                if (!CPU_M2 || nCPU_RW) w_viol++;
            end
            if (nCPU_RW && (CPU_D0 || CPU_D7)) w_viol++;
            if (!nCPU_ROMSEL && prev_rom) begin
                if (w_nwr < 5) begin
                    w_d0[w_nwr] = CPU_D0;
                    w_d7[w_nwr] = CPU_D7;
                end
                if (w_nwr == 0) w_a = {CPU_A14, CPU_A13};
                else if ({CPU_A14, CPU_A13} != w_a) w_adiff++;
                w_nwr++;
            end
            prev_rom = nCPU_ROMSEL;
        end
        if (!w_done) begin
            n_cmp++;
            n_bad++;
            $error("FAIL watch_timeout: observed no DONE expected DONE within %0d clk", budget);
        end
    endtask

    initial begin
        RST = 1'b1; REQ_VALID = 1'b0; REQ_REG = 2'b00; REQ_DATA = 5'd0; REQ_RESET = 1'b0;

        // Reset values
        repeat (3) step();
        chk("reset_outputs", 32'({CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D0,
                                  CPU_D7, REQ_READY, BUSY, DONE}), 32'h180);
        RST = 1'b0;
        step();
        chk("ready_after_reset", 32'(REQ_READY), 32'd1);
        m2v[0] = CPU_M2;
        for (int i = 1; i < 8; i++) begin
            step();
            m2v[i] = CPU_M2;
        end
        chk("m2_period4", 32'(m2v), 32'h66);
        chk("idle_busy", 32'(BUSY), 32'd0);

        // Load: control register <- 0x0C
        send(2'b00, 5'h0C, 1'b0, 1'b0);
        watch(80, 1'b0);
        chk("load_nwr", 32'(w_nwr), 32'd5);
        chk("load_romlow_clks", 32'(w_romlow), 32'd10);
        chk("load_rwlow_clks", 32'(w_rwlow), 32'd20);
        chk("load_d0", 32'(w_d0), 32'h0C);
        chk("load_d7", 32'(w_d7), 32'h00);
        chk("load_addr", 32'({w_a, 30'(w_adiff)}), 32'h0);
        chk("load_wr_to_done", 32'(w_wr2done), 32'd36);
        chk("load_bus_rules", 32'(w_viol), 32'd0);
        chk("load_ready_low", 32'(w_ready_hi), 32'd0);
        chk("fin_ready", 32'(REQ_READY), 32'd1);
        chk("fin_busy", 32'(BUSY), 32'd0);
        step();
        chk("done_one_clk", 32'(DONE), 32'd0);

        // Reset request to PRG register
        send(2'b11, 5'h1F, 1'b1, 1'b0);
        watch(40, 1'b0);
        chk("rstreq_nwr", 32'(w_nwr), 32'd1);
        chk("rstreq_d7", 32'(w_d7), 32'h01);
        chk("rstreq_d0", 32'(w_d0), 32'h00);
        chk("rstreq_addr", 32'(w_a), 32'd3);
        chk("rstreq_wr_to_done", 32'(w_wr2done), 32'd4);
        chk("rstreq_bus_rules", 32'(w_viol), 32'd0);
        step();
        chk("idle_addr_hold", 32'({CPU_A14, CPU_A13}), 32'd3);
        REQ_RESET = 1'b0;

        // Back-to-back: VALID stays high across both requests
        send(2'b01, 5'h15, 1'b0, 1'b1);
        REQ_REG  = 2'b10;
        REQ_DATA = 5'h0A;
        watch(80, 1'b0);
        chk("b2b1_d0", 32'(w_d0), 32'h15);
        chk("b2b1_addr", 32'(w_a), 32'd1);
        chk("b2b1_ready_low", 32'(w_ready_hi), 32'd0);
        chk("b2b_fin_ready", 32'(REQ_READY), 32'd1);
        step();
        REQ_VALID = 1'b0;
        chk("b2b_accept_in_fin", 32'(BUSY), 32'd1);
        watch(80, 1'b0);
        chk("b2b2_d0", 32'(w_d0), 32'h0A);
        chk("b2b2_addr", 32'(w_a), 32'd2);
        chk("b2b2_nwr", 32'(w_nwr), 32'd5);
        // FIN clock + accept clock + lead = one idle CPU cycle (4 clk)
        chk("b2b_idle_lead", 32'(w_lead), 32'd2);

        // Busy hold-off: inputs wiggle during the load
        step();
        send(2'b01, 5'h13, 1'b0, 1'b0);
        watch(80, 1'b1);
        REQ_VALID = 1'b0;
        chk("holdoff_d0", 32'(w_d0), 32'h13);
        chk("holdoff_nwr", 32'(w_nwr), 32'd5);
        chk("holdoff_ready_low", 32'(w_ready_hi), 32'd0);
        chk("holdoff_addr", 32'(w_a), 32'd1);

        // Mid-op reset during the third write
        step();
        send(2'b00, 5'h1F, 1'b0, 1'b0);
        falls = 0;
        prev  = nCPU_ROMSEL;
        for (int k = 0; k < 60 && falls < 3; k++) begin
            step();
            if (!nCPU_ROMSEL && prev) falls++;
            prev = nCPU_ROMSEL;
        end
        chk("midrst_reached_w3", 32'(falls), 32'd3);
        RST = 1'b1;
        step();
        chk("midrst_bus", 32'({nCPU_ROMSEL, nCPU_RW, CPU_D0, CPU_D7, CPU_A14, CPU_A13}),
            32'h30);
        chk("midrst_flags", 32'({DONE, BUSY, REQ_READY, CPU_M2}), 32'h0);
        step();
        chk("midrst_no_done", 32'(DONE), 32'd0);
        RST = 1'b0;
        step();
        chk("midrst_ready", 32'(REQ_READY), 32'd1);
        send(2'b10, 5'h11, 1'b0, 1'b0);
        watch(80, 1'b0);
        chk("post_rst_d0", 32'(w_d0), 32'h11);
        chk("post_rst_addr", 32'(w_a), 32'd2);
        chk("post_rst_nwr", 32'(w_nwr), 32'd5);
        chk("post_rst_bus_rules", 32'(w_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
